// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared definitions for the divider arbiter:
//   - state_e  : arbiter FSM states (IDLE, ISSUE, WAIT, DONE)
//   - clog2    : ceiling log2 for parameter derivation
//   - id_width : requester-ID width, never narrower than one bit
// ---------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

  // A requester index needs at least one bit even when clog2 returns 0.
  function automatic int id_width(input int reqs);
    int w;
    w = clog2(reqs);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/div_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. The search starts one position after
// ptr and wraps modulo REQS, so the last winner has the lowest priority.
// The pointer register itself lives in the parent.
// Ports:
//   req   in  REQS  request vector
//   ptr   in  IW    index of the previous winner
//   gnt   out REQS  one-hot winner (all zero when nothing is requested)
//   idx   out IW    binary index of the winner
//   valid out 1     at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
  import div_pkg::*;
#(
  parameter int REQS = 4,
  parameter int IW   = id_width(REQS)
) (
  input  logic [REQS-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [REQS-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  // Scan ptr+1, ptr+2, ... (mod REQS) and keep the first requester found.
  always_comb begin
    logic [IW-1:0] cand_idx;
    int            cand;
    gnt      = {REQS{1'b0}};
    idx      = {IW{1'b0}};
    valid    = 1'b0;
    cand_idx = {IW{1'b0}};
    cand     = 0;
    for (int k = 1; k <= REQS; k++) begin
      cand     = (int'(ptr) + k) % REQS;
      cand_idx = IW'(cand);
      if (!valid && req[cand_idx]) begin
        valid = 1'b1;
        idx   = cand_idx;
      end else begin
        valid = valid;
      end
    end
    if (valid) begin
      gnt[idx] = 1'b1;
    end else begin
      gnt = {REQS{1'b0}};
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// ---------------------------------------------------------------------------
// div_arbiter
// Shares one sequential divider between REQS requesters. A round-robin winner
// has its operands captured, the divider is started with a one-cycle pulse,
// and the result is returned on res_* together with a done pulse tagged to
// the winner. This block is the only driver of div_start.
//
// Optional feature, macro DIV_ARB_ZERO_BYPASS_EN:
//   a winner whose divisor is zero skips the divider and goes IDLE -> DONE
//   with res_ovf=1, res_q=all ones, res_r=dividend[N-1:0].
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   req/req_a/req_b     request levels and flattened operands per requester
//   gnt                 one-hot pulse: operands of requester i captured this edge
//   done                one-hot pulse: result for requester i valid this cycle
//   res_q/res_r/res_ovf registered quotient, remainder, overflow
//   busy                high in every state except IDLE
//   div_start           start pulse to the divider
//   div_a/div_b         captured operands, stable from ISSUE through DONE
//   div_rdy/div_q/div_r/div_ovf  divider handshake and results
// ---------------------------------------------------------------------------
module div_arbiter
  import div_pkg::*;
#(
  parameter int N    = 4,
  parameter int REQS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REQS-1:0]   req,
  input  logic [REQS*2*N-1:0] req_a,
  input  logic [REQS*N-1:0] req_b,
  output logic [REQS-1:0]   gnt,
  output logic [REQS-1:0]   done,
  output logic [N-1:0]      res_q,
  output logic [N-1:0]      res_r,
  output logic              res_ovf,
  output logic              busy,
  output logic              div_start,
  output logic [2*N-1:0]    div_a,
  output logic [N-1:0]      div_b,
  input  logic              div_rdy,
  input  logic [N-1:0]      div_q,
  input  logic [N-1:0]      div_r,
  input  logic              div_ovf
);

  localparam int IW = id_width(REQS);

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   tag_q, tag_d;
  logic            wait_first_q, wait_first_d;
  logic [2*N-1:0]  opa_q, opa_d;
  logic [N-1:0]    opb_q, opb_d;
  logic [N-1:0]    quot_q, quot_d;
  logic [N-1:0]    rem_q, rem_d;
  logic            ovf_q, ovf_d;

  logic [REQS-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_valid;
  logic [2*N-1:0]  win_a;
  logic [N-1:0]    win_b;

  rr_arbiter #(
    .REQS (REQS),
    .IW   (IW)
  ) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // Select the winner's operand slices.
  always_comb begin
    win_a = {(2*N){1'b0}};
    win_b = {N{1'b0}};
    for (int i = 0; i < REQS; i++) begin
      if (arb_idx == IW'(i)) begin
        win_a = req_a[i*2*N +: 2*N];
        win_b = req_b[i*N +: N];
      end else begin
        win_a = win_a;
      end
    end
  end

  // Next-state, capture and grant logic.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    tag_d        = tag_q;
    wait_first_d = wait_first_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    quot_d       = quot_q;
    rem_d        = rem_q;
    ovf_d        = ovf_q;
    gnt          = {REQS{1'b0}};
    case (state_q)
      ST_IDLE: begin
        // Gated by rst so no grant is shown while the block is being reset.
        if (!rst && arb_valid && div_rdy) begin
          gnt          = arb_gnt;
          opa_d        = win_a;
          opb_d        = win_b;
          tag_d        = arb_idx;
          ptr_d        = arb_idx;
          wait_first_d = 1'b1;
`ifdef DIV_ARB_ZERO_BYPASS_EN
          if (win_b == {N{1'b0}}) begin
            state_d = ST_DONE;
            quot_d  = {N{1'b1}};
            rem_d   = win_a[N-1:0];
            ovf_d   = 1'b1;
          end else begin
            state_d = ST_ISSUE;
          end
`else
          state_d = ST_ISSUE;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d      = ST_WAIT;
        wait_first_d = 1'b1;
      end
      ST_WAIT: begin
        // The divider may still show ready in the first WAIT cycle, so that
        // cycle is skipped before div_rdy is trusted.
        if (wait_first_q) begin
          wait_first_d = 1'b0;
        end else if (div_rdy) begin
          quot_d  = div_q;
          rem_d   = div_r;
          ovf_d   = div_ovf;
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Done pulse decoded from the registered state and tag.
  always_comb begin
    done = {REQS{1'b0}};
    if (state_q == ST_DONE) begin
      done[tag_q] = 1'b1;
    end else begin
      done = {REQS{1'b0}};
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= IW'(REQS - 1);
      tag_q        <= {IW{1'b0}};
      wait_first_q <= 1'b0;
      opa_q        <= {(2*N){1'b0}};
      opb_q        <= {N{1'b0}};
      quot_q       <= {N{1'b0}};
      rem_q        <= {N{1'b0}};
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      tag_q        <= tag_d;
      wait_first_q <= wait_first_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      quot_q       <= quot_d;
      rem_q        <= rem_d;
      ovf_q        <= ovf_d;
    end
  end

  assign res_q     = quot_q;
  assign res_r     = rem_q;
  assign res_ovf   = ovf_q;
  assign div_a     = opa_q;
  assign div_b     = opb_q;
  assign busy      = (state_q != ST_IDLE);
  assign div_start = (state_q == ST_ISSUE);

endmodule
